ru_data_mem: RTL and testbench
==============================

RU_DATA_MEM -- requirements
Module: ru_data_mem

Interface
REQ-001 SHALL provide parameter DEPTH_WORDS, default 64, number of 32-bit words stored.
REQ-002 SHALL provide parameter WAIT_CYCLES, default 0, access latency in cycles (0..15).
REQ-003 SHALL provide parameter DISPLAY_ADDR, default 32'h0, byte address mirrored to display.
REQ-004 SHALL provide port clk  in  1  clock, all state updates on rising edge.
REQ-005 SHALL provide port nRst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL provide port req_valid  in  1  access request.
REQ-007 SHALL provide port write_enable  in  1  1=store, 0=load.
REQ-008 SHALL provide port size  in  2  access size: 0=byte, 1=half, 2=word; 3 is illegal and SHALL error.
REQ-009 SHALL provide port load_unsigned  in  1  1=zero-extend loads, 0=sign-extend loads.
REQ-010 SHALL provide port addr  in  32  byte address.
REQ-011 SHALL provide port data_in  in  32  store data, right-aligned.
REQ-012 SHALL provide port data_out  out  32  extended load data, valid while done=1.
REQ-013 SHALL provide port busy  out  1  access in progress; core stalls while 1.
REQ-014 SHALL provide port done  out  1  single-cycle completion pulse.
REQ-015 SHALL provide port err  out  1  completion with fault; qualified by done.
REQ-016 SHALL provide port display  out  32  mirror of word at DISPLAY_ADDR.

Function
REQ-017 SHALL implement states IDLE and WAIT, plus a 4-bit wait counter.
REQ-018 SHALL, when WAIT_CYCLES=0, complete an IDLE request in the same cycle: done=1, busy=0, data_out combinational from addr, store committed at that rising edge.
REQ-019 SHALL, when WAIT_CYCLES>0, on an IDLE request drive busy=1 combinationally, latch addr/data_in/size/write_enable/load_unsigned at the edge, load counter=WAIT_CYCLES-1, and enter WAIT.
REQ-020 SHALL, in WAIT with counter>0, hold busy=1 and decrement the counter each cycle.
REQ-021 SHALL, in WAIT with counter=0, drive busy=0, done=1 and data_out from the latched request, commit any store at that edge, and return to IDLE.
REQ-022 SHALL give a request in cycle 0 busy=1 for cycles 0..WAIT_CYCLES-1 and done=1 in cycle WAIT_CYCLES.
REQ-023 SHALL ignore req_valid and input changes while in WAIT.
REQ-024 SHALL write only the addressed byte lanes: byte writes lane addr[1:0]; half writes lanes addr[1]*2..+1; word writes all four lanes.
REQ-025 SHALL shift load data right by lane, then zero- or sign-extend it per size and load_unsigned.
REQ-026 SHALL flag err=1 with done for any of: misaligned half (addr[0]=1), misaligned word (addr[1:0]!=0), size=3, or addr>=DEPTH_WORDS*4.
REQ-027 SHALL, on err, suppress the store and drive data_out=0.
REQ-028 SHALL drive data_out=0, err=0 and done=0 whenever done is not asserted.

Reset
REQ-029 SHALL, on nRst low, immediately force state=IDLE, counter=0, busy=0, done=0, err=0, data_out=0, display=0.
REQ-030 SHALL discard a pending store when reset occurs mid-WAIT.
REQ-031 SHALL NOT clear array contents on reset.

Configuration
REQ-032 SHALL, with RU_DATA_MEM_DISPLAY_EN defined, keep a display register that updates at the same edge as any successful store touching the word at DISPLAY_ADDR, merging the written lanes.
REQ-033 SHALL, without RU_DATA_MEM_DISPLAY_EN, tie display to 0 and add no register; memory behaviour is unchanged.

Structure
REQ-034 SHALL place the size encoding enum (BYTE, HALF, WORD), the state enum (IDLE, WAIT) and the WAIT_CYCLES maximum constant in package ru_data_mem_pkg.
REQ-035 SHALL use sub-module ru_data_mem_align, a combinational block that produces write byte-enables and shifted write data, and performs load extraction and extension.

Verification
REQ-036 SHALL cover: WAIT_CYCLES=0, store word 0xDEADBEEF to 0x8, then load word 0x8 -> data_out=0xDEADBEEF, done=1 in the request cycle.
REQ-037 SHALL cover: store byte 0x80 to 0x9 over 0x00000000, then load byte signed 0x9 -> 0xFFFFFF80; load unsigned -> 0x00000080; word at 0x8 reads 0x00008000.
REQ-038 SHALL cover: WAIT_CYCLES=3, load request at cycle 0 -> busy=1 in cycles 0-2, done=1 in cycle 3, input changes in cycles 1-2 ignored.
REQ-039 SHALL cover: load half from 0x3 -> done=1, err=1, data_out=0; store word to DEPTH_WORDS*4 -> err=1, memory unchanged.
REQ-040 SHALL cover: WAIT_CYCLES=2, store issued, nRst pulsed in cycle 1 -> outputs zero, later read returns the old value.
REQ-041 SHALL cover: with RU_DATA_MEM_DISPLAY_EN, store half 0x1234 to DISPLAY_ADDR+2 -> display=0x12340000 after the commit edge.

Source files
------------

// File: rtl/ru_data_mem_pkg.sv
// Shared types and constants for the ru_data_mem data memory.
package ru_data_mem_pkg;

    // Access size encoding on the size port; 2'd3 is illegal.
    typedef enum logic [1:0] {
        SizeByte = 2'd0,
        SizeHalf = 2'd1,
        SizeWord = 2'd2
    } size_e;

    typedef enum logic {
        StIdle = 1'b0,
        StWait = 1'b1
    } state_e;

    // Wait counter is 4 bits wide.
    localparam int unsigned MaxWaitCycles = 15;

    // Replace only the byte lanes selected by be, keep the rest of old_word.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ru_data_mem_align.sv
// Lane steering for ru_data_mem: store byte-enables and shifted store data,
// plus load extraction with zero/sign extension. Purely combinational.
module ru_data_mem_align
    import ru_data_mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic        load_unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;
    logic        sign_b;
    logic        sign_h;

    // Decode size into lane enables and extract/extend the loaded bits.
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = 32'h0;
        rdata_o = 32'h0;
        shifted = rword_i >> {lane_i, 3'b000};
        sign_b  = ~load_unsigned_i & shifted[7];
        sign_h  = ~load_unsigned_i & shifted[15];
        case (size_i)
            SizeByte: begin
                be_o    = 4'b0001 << lane_i;
                wdata_o = wdata_i << {lane_i, 3'b000};
                rdata_o = {{24{sign_b}}, shifted[7:0]};
            end
            SizeHalf: begin
                be_o    = 4'b0011 << {lane_i[1], 1'b0};
                wdata_o = wdata_i << {lane_i[1], 4'b0000};
                rdata_o = {{16{sign_h}}, shifted[15:0]};
            end
            SizeWord: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = shifted;
            end
            default: begin
                be_o    = 4'b0000;
                wdata_o = 32'h0;
                rdata_o = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/ru_data_mem.sv
// Data memory with optional fixed access latency and byte/half/word accesses.
// Optional display mirror register enabled with `define RU_DATA_MEM_DISPLAY_EN.
module ru_data_mem
    import ru_data_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS  = 64,
    parameter int unsigned WAIT_CYCLES  = 0,   // 0..MaxWaitCycles
    parameter logic [31:0] DISPLAY_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        req_valid,
    input  logic        write_enable,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] display
);

    localparam int unsigned IdxW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] MemBytes = 33'(DEPTH_WORDS) * 33'd4;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic        eff_we;
    logic [1:0]  eff_size;
    logic        eff_uns;
    logic [31:0] eff_addr;
    logic [31:0] eff_wdata;
    logic        idle_req;
    logic        start_wait;
    logic        complete;
    logic        busy_int;
    logic        fault;
    logic        commit;
    logic [IdxW-1:0] word_idx;
    logic [31:0] rword;
    logic [3:0]  be;
    logic [31:0] wdata_sh;
    logic [31:0] rdata;

    // Select the live inputs in IDLE or the latched request in WAIT, and decode completion.
    always_comb begin
        if (state_q == StWait) begin
            eff_we    = we_q;
            eff_size  = size_q;
            eff_uns   = uns_q;
            eff_addr  = addr_q;
            eff_wdata = wdata_q;
        end else begin
            eff_we    = write_enable;
            eff_size  = size;
            eff_uns   = load_unsigned;
            eff_addr  = addr;
            eff_wdata = data_in;
        end
        idle_req = (state_q == StIdle) && req_valid;
        if (WAIT_CYCLES == 0) begin
            start_wait = 1'b0;
            complete   = idle_req;
        end else begin
            start_wait = idle_req;
            complete   = (state_q == StWait) && (cnt_q == 4'd0);
        end
        busy_int = start_wait || ((state_q == StWait) && (cnt_q != 4'd0));
        fault    = (eff_size == 2'd3)
                || ((eff_size == SizeHalf) && eff_addr[0])
                || ((eff_size == SizeWord) && (eff_addr[1:0] != 2'b00))
                || ({1'b0, eff_addr} >= MemBytes);
        // Reset also blocks a same-cycle commit when WAIT_CYCLES is zero.
        commit   = complete && eff_we && !fault && nRst;
        word_idx = eff_addr[IdxW+1:2];
        rword    = mem_q[word_idx];
    end

    ru_data_mem_align u_align (
        .size_i          (eff_size),
        .lane_i          (eff_addr[1:0]),
        .load_unsigned_i (eff_uns),
        .wdata_i         (eff_wdata),
        .rword_i         (rword),
        .be_o            (be),
        .wdata_o         (wdata_sh),
        .rdata_o         (rdata)
    );

    // Outputs are forced low while reset is asserted, without waiting for an edge.
    always_comb begin
        busy     = busy_int && nRst;
        done     = complete && nRst;
        err      = done && fault;
        data_out = (done && !fault && !eff_we) ? rdata : 32'h0;
    end

    // Next-state: latch the request on entry to WAIT, then count down to completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            StIdle: begin
                if (start_wait) begin
                    state_d = StWait;
                    cnt_d   = 4'(WAIT_CYCLES - 1);
                    we_d    = write_enable;
                    size_d  = size;
                    uns_d   = load_unsigned;
                    addr_d  = addr;
                    wdata_d = data_in;
                end
            end
            StWait: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state and latched request; reset drops any pending store.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Storage array: only the enabled lanes change, contents survive reset.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem_q[word_idx] <= merge_lanes(mem_q[word_idx], wdata_sh, be);
        end
    end

`ifdef RU_DATA_MEM_DISPLAY_EN
    logic [31:0] display_q, display_d;

    // Mirror successful stores that hit the display word, lane by lane.
    always_comb begin
        display_d = display_q;
        if (commit && (eff_addr[31:2] == DISPLAY_ADDR[31:2])) begin
            display_d = merge_lanes(display_q, wdata_sh, be);
        end
    end

    // Display register.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            display_q <= 32'h0;
        end else begin
            display_q <= display_d;
        end
    end

    assign display = display_q;
`else
    assign display = 32'h0;
`endif

endmodule

// File: tb/tb_ru_data_mem.sv
// Self-checking bench for ru_data_mem: directed table, randomized traffic against a
// byte-level reference model, and hand sequences for latency and mid-access reset.
module tb_ru_data_mem;

    localparam int unsigned Depth = 16;
    localparam int unsigned Bytes = Depth * 4;
    localparam logic [31:0] DispAddr = 32'h10;

    typedef struct packed {
        logic        req_valid;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] a;
        logic [31:0] d;
        logic        e;
        logic [31:0] q;
    } vec_t;

    logic        clk;
    logic        nRst;
    logic        nRst2;
    req_t        rq     [3];
    logic [31:0] dout_o [3];
    logic [31:0] disp_o [3];
    logic        busy_o [3];
    logic        done_o [3];
    logic        err_o  [3];

    logic [7:0]  mb [3][Bytes];
    logic [7:0]  md [4];

    int          vectors;
    int          miscompares;
    vec_t        tbl [18];

    ru_data_mem #(.DEPTH_WORDS(Depth), .WAIT_CYCLES(0), .DISPLAY_ADDR(DispAddr)) u_dut0 (
        .clk(clk), .nRst(nRst), .req_valid(rq[0].req_valid), .write_enable(rq[0].we),
        .size(rq[0].size), .load_unsigned(rq[0].uns), .addr(rq[0].addr),
        .data_in(rq[0].data), .data_out(dout_o[0]), .busy(busy_o[0]), .done(done_o[0]),
        .err(err_o[0]), .display(disp_o[0])
    );

    ru_data_mem #(.DEPTH_WORDS(Depth), .WAIT_CYCLES(3), .DISPLAY_ADDR(DispAddr)) u_dut3 (
        .clk(clk), .nRst(nRst), .req_valid(rq[1].req_valid), .write_enable(rq[1].we),
        .size(rq[1].size), .load_unsigned(rq[1].uns), .addr(rq[1].addr),
        .data_in(rq[1].data), .data_out(dout_o[1]), .busy(busy_o[1]), .done(done_o[1]),
        .err(err_o[1]), .display(disp_o[1])
    );

    ru_data_mem #(.DEPTH_WORDS(Depth), .WAIT_CYCLES(2), .DISPLAY_ADDR(DispAddr)) u_dut2 (
        .clk(clk), .nRst(nRst2), .req_valid(rq[2].req_valid), .write_enable(rq[2].we),
        .size(rq[2].size), .load_unsigned(rq[2].uns), .addr(rq[2].addr),
        .data_in(rq[2].data), .data_out(dout_o[2]), .busy(busy_o[2]), .done(done_o[2]),
        .err(err_o[2]), .display(disp_o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wait_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 3 : 2);
    endfunction

    function automatic logic [31:0] disp_exp();
`ifdef RU_DATA_MEM_DISPLAY_EN
        return {md[3], md[2], md[1], md[0]};
`else
        return 32'h0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: byte-addressed memory, accesses of 1<<size bytes, little-endian.
    task automatic model_access(input int k, input logic we, input logic [1:0] sz,
                                input logic uns, input logic [31:0] a, input logic [31:0] d,
                                output logic e, output logic [31:0] v);
        int n;
        e = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)
            || (a >= Bytes);
        v = 32'h0;
        if (!e) begin
            n = 1 << sz;
            if (we) begin
                for (int i = 0; i < n; i++) begin
                    mb[k][int'(a) + i] = d[8*i +: 8];
                    if (k == 0 && (int'(a) + i) >= int'(DispAddr)
                        && (int'(a) + i) < int'(DispAddr) + 4) begin
                        md[int'(a) + i - int'(DispAddr)] = d[8*i +: 8];
                    end
                end
            end else begin
                for (int i = 0; i < n; i++) v[8*i +: 8] = mb[k][int'(a) + i];
                if (!uns && n < 4 && v[8*n-1]) begin
                    for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
                end
            end
        end
    endtask

    // Issue one request; returns the cycle (relative to issue) in which done was seen.
    task automatic access(input int k, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] d, input bit scr,
                          output int dc, output logic e, output logic [31:0] q,
                          output bit bok);
        rq[k] = '{1'b1, we, sz, uns, a, d};
        dc = -1;
        bok = 1'b1;
        e = 1'b0;
        q = 32'h0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done_o[k]) begin
                dc = c;
                e = err_o[k];
                q = dout_o[k];
                if (busy_o[k]) bok = 1'b0;
                break;
            end
            if (!busy_o[k] || err_o[k] || dout_o[k] != 32'h0) bok = 1'b0;
            @(posedge clk);
            #1;
            if (scr) begin
                rq[k] = '{1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                          $urandom, $urandom};
            end
        end
        @(posedge clk);
        #1;
        rq[k].req_valid = 1'b0;
    endtask

    task automatic do_vec(input int k, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] d, input bit scr,
                          input bit use_tbl, input logic te, input logic [31:0] tq);
        logic        me;
        logic [31:0] mq;
        int          dc;
        logic        e;
        logic [31:0] q;
        bit          bok;
        model_access(k, we, sz, uns, a, d, me, mq);
        if (use_tbl) begin
            me = te;
            mq = tq;
        end
        access(k, we, sz, uns, a, d, scr, dc, e, q, bok);
        chk($sformatf("latency k%0d a%h", k, a), 32'(dc), 32'(wait_of(k)));
        chk($sformatf("busy_pattern k%0d a%h", k, a), {31'b0, bok}, 32'd1);
        if (dc >= 0) begin
            chk($sformatf("err k%0d a%h sz%0d", k, a, sz), {31'b0, e}, {31'b0, me});
            if (!we) chk($sformatf("data_out k%0d a%h sz%0d", k, a, sz), q, mq);
        end
        if (k == 0) chk("display", disp_o[0], disp_exp());
    endtask

    initial begin
        int          dc;
        logic        e;
        logic [31:0] q;
        bit          bok;
        logic [31:0] a;
        logic [1:0]  sz;

        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < 4; i++) md[i] = 8'h00;
        for (int k = 0; k < 3; k++) rq[k] = '0;

        // Reset with a live request on the zero-latency instance: nothing may show.
        nRst = 1'b0;
        nRst2 = 1'b0;
        rq[0] = '{1'b1, 1'b1, 2'd2, 1'b0, 32'h0, 32'h55AA55AA};
        #3;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset busy k%0d", k), {31'b0, busy_o[k]}, 32'h0);
            chk($sformatf("reset done k%0d", k), {31'b0, done_o[k]}, 32'h0);
            chk($sformatf("reset err k%0d", k), {31'b0, err_o[k]}, 32'h0);
            chk($sformatf("reset data_out k%0d", k), dout_o[k], 32'h0);
            chk($sformatf("reset display k%0d", k), disp_o[k], 32'h0);
        end
        @(posedge clk);
        #1;
        rq[0].req_valid = 1'b0;
        @(negedge clk);
        nRst = 1'b1;
        nRst2 = 1'b1;
        @(posedge clk);
        #1;

        // Initialise every word: zeros on the directed instance, random elsewhere.
        for (int w = 0; w < int'(Depth); w++) begin
            do_vec(0, 1'b1, 2'd2, 1'b0, 32'(w * 4), 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
            do_vec(1, 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, 1'b0, 1'b0, 1'b0, 32'h0);
            do_vec(2, 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, 1'b0, 1'b0, 1'b0, 32'h0);
        end

        // Directed table on the zero-latency instance; expected values are literal.
        tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h08, 32'hDEADBEEF, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h08, 32'h0,        1'b0, 32'hDEADBEEF};
        tbl[2]  = '{1'b1, 2'd2, 1'b0, 32'h08, 32'h0,        1'b0, 32'h0};
        tbl[3]  = '{1'b1, 2'd0, 1'b0, 32'h09, 32'h00000080, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 2'd0, 1'b0, 32'h09, 32'h0,        1'b0, 32'hFFFFFF80};
        tbl[5]  = '{1'b0, 2'd0, 1'b1, 32'h09, 32'h0,        1'b0, 32'h00000080};
        tbl[6]  = '{1'b0, 2'd2, 1'b0, 32'h08, 32'h0,        1'b0, 32'h00008000};
        tbl[7]  = '{1'b0, 2'd1, 1'b0, 32'h03, 32'h0,        1'b1, 32'h0};
        tbl[8]  = '{1'b1, 2'd2, 1'b0, 32'h40, 32'h12345678, 1'b1, 32'h0};
        tbl[9]  = '{1'b0, 2'd2, 1'b0, 32'h00, 32'h0,        1'b0, 32'h0};
        tbl[10] = '{1'b0, 2'd3, 1'b0, 32'h00, 32'h0,        1'b1, 32'h0};
        tbl[11] = '{1'b1, 2'd1, 1'b0, 32'h12, 32'h00001234, 1'b0, 32'h0};
        tbl[12] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        1'b0, 32'h12340000};
        tbl[13] = '{1'b1, 2'd1, 1'b0, 32'h0A, 32'hFFFF8001, 1'b0, 32'h0};
        tbl[14] = '{1'b0, 2'd1, 1'b0, 32'h0A, 32'h0,        1'b0, 32'hFFFF8001};
        tbl[15] = '{1'b0, 2'd1, 1'b1, 32'h0A, 32'h0,        1'b0, 32'h00008001};
        tbl[16] = '{1'b0, 2'd2, 1'b0, 32'h02, 32'h0,        1'b1, 32'h0};
        tbl[17] = '{1'b0, 2'd2, 1'b0, 32'h08, 32'h0,        1'b0, 32'h80018000};
        for (int i = 0; i < 18; i++) begin
            do_vec(0, tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].a, tbl[i].d, 1'b0, 1'b1,
                   tbl[i].e, tbl[i].q);
        end
`ifdef RU_DATA_MEM_DISPLAY_EN
        chk("display after half store", disp_o[0], 32'h12340000);
`endif

        // Three-cycle latency with inputs scrambled during WAIT.
        do_vec(1, 1'b1, 2'd2, 1'b0, 32'h04, 32'hA5A50F0F, 1'b1, 1'b0, 1'b0, 32'h0);
        do_vec(1, 1'b0, 2'd2, 1'b0, 32'h04, 32'h0, 1'b1, 1'b1, 1'b0, 32'hA5A50F0F);
        do_vec(1, 1'b0, 2'd1, 1'b0, 32'h06, 32'h0, 1'b1, 1'b1, 1'b0, 32'hFFFFA5A5);

        // Randomized traffic against the model, biased towards aligned addresses.
        for (int n = 0; n < 200; n++) begin
            for (int k = 0; k < 2; k++) begin
                if (k == 1 && n >= 60) continue;
                sz = 2'($urandom_range(0, 3));
                a = 32'($urandom_range(0, Bytes + 7));
                if ($urandom_range(0, 2) != 0) a = a & ~((32'd1 << sz) - 32'd1);
                do_vec(k, 1'($urandom), sz, 1'($urandom), a, $urandom, 1'(k), 1'b0,
                       1'b0, 32'h0);
            end
        end

        // Reset in the middle of a pending store: store dropped, outputs cleared.
        do_vec(2, 1'b1, 2'd2, 1'b0, 32'h14, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 32'h0);
        rq[2] = '{1'b1, 1'b1, 2'd2, 1'b0, 32'h14, 32'h11111111};
        @(negedge clk);
        chk("wait2 busy cycle0", {31'b0, busy_o[2]}, 32'h1);
        @(posedge clk);
        #1;
        rq[2].req_valid = 1'b0;
        nRst2 = 1'b0;
        #1;
        chk("midreset busy", {31'b0, busy_o[2]}, 32'h0);
        chk("midreset done", {31'b0, done_o[2]}, 32'h0);
        chk("midreset err", {31'b0, err_o[2]}, 32'h0);
        chk("midreset data_out", dout_o[2], 32'h0);
        @(negedge clk);
        nRst2 = 1'b1;
        @(posedge clk);
        #1;
        access(2, 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 1'b0, dc, e, q, bok);
        chk("post-reset latency", 32'(dc), 32'd2);
        chk("post-reset err", {31'b0, e}, 32'h0);
        chk("post-reset old value", q, 32'hCAFEF00D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
